mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage load/store unit for the combined ARM/RISC-V pipeline, directly downstream of the execute-stage ALU.
- Consumes the ALU result, held in the EX/MEM register, as the byte address, together with store data and size/sign controls.
- Drives a single-outstanding req/gnt/rvalid data bus, stalls the pipeline while a transaction is in flight, and presents aligned, extended load data to writeback.

Parameters:
- WAIT_TIMEOUT, 255: maximum cycles in WAIT before the read is abandoned with a fault; range 1..65535.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- MemReqM  in  1  memory operation present in M stage
- MemWriteM  in  1  1 = store, 0 = load
- MemSizeM  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word
- MemSignedM  in  1  load sign-extends when 1 (ignored for word and for stores)
- ALUResultM  in  32  byte address from the ALU
- WriteDataM  in  32  store data, right-aligned
- StallM  out  1  freeze IF..M stages this cycle
- ReadDataW  out  32  extended load result, registered
- MisalignedM  out  1  one-cycle pulse: misaligned access rejected
- FaultM  out  1  one-cycle pulse: bus error or read timeout
- bus_req  out  1  request valid; held until bus_gnt
- bus_we  out  1  write request
- bus_addr  out  32  word address, {ALUResultM[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data
- bus_err  in  1  error, qualified by bus_gnt for writes and by bus_rvalid for reads

Behaviour:
- Reset (async, reset_n=0): state IDLE, bus_req/bus_we=0, bus_addr/bus_be/bus_wdata=0, ReadDataW=0, MisalignedM/FaultM=0, timeout counter=0. StallM is combinational and reads 0 in IDLE with MemReqM=0. Reset mid-transaction drops bus_req immediately; any late gnt/rvalid is ignored.
- Alignment: off = ALUResultM[1:0].
  - Half with off odd, or word with off!=0, is misaligned.
  - Misaligned access: no bus request; MisalignedM=1 on the next cycle for one cycle; StallM=0.
- Byte enables and store data:
  - Byte: be = 1<<off; wdata = {4{WriteDataM[7:0]}}.
  - Half: be = 0011 (off 0) or 1100 (off 2); wdata = {2{WriteDataM[15:0]}}.
  - Word: be = 1111; wdata = WriteDataM.
- FSM IDLE -> REQ -> (WAIT) -> IDLE:
  - IDLE, valid aligned MemReqM:
    - StallM=1.
    - Register bus_addr/bus_we/bus_be/bus_wdata, plus size, sign and off for load extraction.
    - Set bus_req=1 and go to REQ.
  - REQ:
    - bus_req=1; bus outputs stable until bus_gnt.
    - On bus_gnt, bus_req=0 next cycle.
    - Write + gnt: transaction completes; StallM=0 this cycle; FaultM pulses next cycle if bus_err; go to IDLE.
    - Read + gnt: go to WAIT with StallM=1. rvalid in the gnt cycle is not sampled.
    - Without gnt: stay in REQ; there is no timeout in REQ.
  - WAIT:
    - Counter increments each cycle.
    - On bus_rvalid: StallM=0; ReadDataW loads the extracted value at that edge (0 if bus_err, with FaultM pulsing next cycle); go to IDLE.
    - If counter reaches WAIT_TIMEOUT before rvalid: StallM=0 that cycle; ReadDataW=0; FaultM pulses next cycle; go to IDLE; counter clears.
    - A stray rvalid arriving in IDLE/REQ is ignored.
- Load extraction: select byte lane off or half lane off[1]; zero-extend, or sign-extend when MemSignedM=1; word passes through.
- Back-to-back: StallM=0 at completion advances the pipeline, so a new MemReqM seen in IDLE on the next cycle starts immediately. Throughput is at best one store per 2 cycles and one load per 3 cycles.
- Outputs other than StallM are registered. StallM depends combinationally on state, MemReqM, bus_gnt, bus_rvalid and the timeout compare.

Test Plan:
- Store byte: ALUResultM=0x1003, WriteDataM=0xAB, gnt after 2 cycles -> bus_addr=0x1000, be=1000, wdata=0xABABABAB, bus_req high 3 cycles, StallM low in gnt cycle.
- Signed half load: addr 0x2002, gnt immediate, rvalid 1 cycle later with rdata=0x8001_1234, MemSignedM=1 -> ReadDataW=0xFFFF8001; with MemSignedM=0 -> 0x00008001.
- Misaligned word: addr 0x3001 -> no bus_req, MisalignedM pulse 1 cycle later, StallM never asserts.
- Timeout: WAIT_TIMEOUT=4, read granted, no rvalid -> StallM drops after 4 WAIT cycles, FaultM pulses, ReadDataW=0, then a late rvalid is ignored.
- Bus error on write gnt -> FaultM pulse; next store accepted the following cycle.
- reset_n low while in REQ -> bus_req=0 immediately, all outputs at reset values, and a new load after release completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: drives a single-outstanding req/gnt/rvalid bus,
// stalls the pipeline while a transaction is in flight and extends load data.
module mem_access_unit #(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignedM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataW,
    output logic        MisalignedM,
    output logic        FaultM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);
    // Bus handshake: bus_req and its payload are held stable until a cycle with
    // bus_gnt=1; for reads, data is taken only on a later cycle with bus_rvalid=1.
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [1:0]  size_q, off_q;
    logic        sgn_q;
    logic [1:0]  off;
    logic        misaligned, start, timeout_hit;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, load_val;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign off         = ALUResultM[1:0];
    assign misaligned  = (MemSizeM == 2'b01 && off[0]) || (MemSizeM[1] && off != 2'b00);
    assign start       = (state == IDLE) && MemReqM && !misaligned;
    assign timeout_hit = (cnt == 16'(WAIT_TIMEOUT - 1));

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = WriteDataM;
        case (MemSizeM)
            2'b00: begin
                be_d    = 4'b0001 << off;
                wdata_d = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_d    = off[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the offset captured at request time, not the live ALU result.
    always_comb begin
        byte_v   = bus_rdata[{off_q, 3'b000} +: 8];
        half_v   = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_val = bus_rdata;
        case (size_q)
            2'b00:   load_val = {{24{sgn_q & byte_v[7]}}, byte_v};
            2'b01:   load_val = {{16{sgn_q & half_v[15]}}, half_v};
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        StallM    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    StallM    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                StallM = !(bus_gnt && bus_we);
                if (bus_gnt) state_nxt = bus_we ? IDLE : WAIT;
            end
            WAIT: begin
                StallM = !(bus_rvalid || timeout_hit);
                if (bus_rvalid || timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            size_q      <= '0;
            off_q       <= '0;
            sgn_q       <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            ReadDataW   <= '0;
            MisalignedM <= 1'b0;
            FaultM      <= 1'b0;
        end else begin
            state       <= state_nxt;
            MisalignedM <= (state == IDLE) && MemReqM && misaligned;
            FaultM      <= 1'b0;

            if (state == WAIT && state_nxt == WAIT) cnt <= cnt + 16'd1;
            else                                    cnt <= '0;

            if (start) begin
                bus_req   <= 1'b1;
                bus_we    <= MemWriteM;
                bus_addr  <= {ALUResultM[31:2], 2'b00};
                bus_be    <= be_d;
                bus_wdata <= wdata_d;
                size_q    <= MemSizeM;
                off_q     <= off;
                sgn_q     <= MemSignedM;
            end

            if (state == REQ && bus_gnt) begin
                bus_req <= 1'b0;
                if (bus_we) FaultM <= bus_err;
            end

            // rvalid takes priority over a timeout landing in the same cycle.
            if (state == WAIT) begin
                if (bus_rvalid) begin
                    ReadDataW <= bus_err ? 32'd0 : load_val;
                    FaultM    <= bus_err;
                end else if (timeout_hit) begin
                    ReadDataW <= '0;
                    FaultM    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan cases plus randomized transactions
// checked cycle by cycle against an arithmetic model of the access rules.
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MemReqM, MemWriteM, MemSignedM;
    logic [1:0]  MemSizeM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM, MisalignedM, FaultM;
    logic [31:0] ReadDataW;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid, bus_err;
    logic [31:0] bus_rdata;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        exp_fault = 1'b0;
    logic        exp_mis = 1'b0;
    logic [31:0] exp_rd = '0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .MemReqM(MemReqM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
        .MemSignedM(MemSignedM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataW(ReadDataW), .MisalignedM(MisalignedM), .FaultM(FaultM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic mis_f(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'd1) return (off % 2) != 0;
        if (size >= 2'd2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'd0) return 4'(2 ** off);
        if (size == 2'd1) return (off < 2) ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] wd_f(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return 32'(wd[7:0]) * 32'h0101_0101;
        if (size == 2'd1) return 32'(wd[15:0]) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ld_f(input logic [1:0] size, input logic sgn,
                                         input logic [1:0] off, input logic [31:0] rd);
        int unsigned bits, shift;
        logic [63:0] v;
        if (size >= 2'd2) return rd;
        bits  = (size == 2'd0) ? 8 : 16;
        shift = (size == 2'd0) ? 32'(off) * 8 : (32'(off) / 2) * 16;
        v = (64'(rd) >> shift) % (64'd1 << bits);
        if (sgn && v >= (64'd1 << (bits - 1)))
            v = v + 64'hFFFF_FFFF - ((64'd1 << bits) - 64'd1);
        return v[31:0];
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_common();
        if (exp_q.size() > 0) exp_rd = exp_q.pop_front();
        check("fault", 32'(FaultM), 32'(exp_fault));
        check("misaligned", 32'(MisalignedM), 32'(exp_mis));
        check("read_data_w", ReadDataW, exp_rd);
        exp_fault = 1'b0;
        exp_mis   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic idle();
        MemReqM    = 1'b0;
        bus_gnt    = 1'b0;
        bus_err    = 1'b0;
        bus_rvalid = 1'($urandom_range(0, 1));
        bus_rdata  = $urandom;
        @(negedge clk);
        chk_common();
        check("idle_stall", 32'(StallM), 32'd0);
        check("idle_req", 32'(bus_req), 32'd0);
        tick();
    endtask

    task automatic txn(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                       input int gnt_dly, input int rv_dly, input logic err);
        logic mis, to, last;
        int   n;
        mis = mis_f(size, addr[1:0]);
        MemReqM    = 1'b1;
        MemWriteM  = we;
        MemSizeM   = size;
        MemSignedM = sgn;
        ALUResultM = addr;
        WriteDataM = wd;
        bus_gnt    = 1'b0;
        bus_err    = 1'b0;
        bus_rvalid = 1'($urandom_range(0, 1));
        bus_rdata  = $urandom;
        @(negedge clk);
        chk_common();
        check("start_stall", 32'(StallM), 32'(!mis));
        check("start_req", 32'(bus_req), 32'd0);
        tick();
        if (mis) begin
            MemReqM = 1'b0;
            exp_mis = 1'b1;
            return;
        end
        for (int i = 0; i <= gnt_dly; i++) begin
            last       = (i == gnt_dly);
            bus_gnt    = last;
            bus_err    = (last && we) ? err : 1'($urandom_range(0, 1));
            bus_rvalid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("req", 32'(bus_req), 32'd1);
            check("we", 32'(bus_we), 32'(we));
            check("addr", bus_addr, {addr[31:2], 2'b00});
            check("be", 32'(bus_be), 32'(be_f(size, addr[1:0])));
            check("wdata", bus_wdata, wd_f(size, wd));
            check("req_stall", 32'(StallM), 32'(!(we && last)));
            tick();
        end
        bus_gnt = 1'b0;
        if (we) begin
            MemReqM    = 1'b0;
            bus_err    = 1'b0;
            bus_rvalid = 1'($urandom_range(0, 1));
            exp_fault  = err;
            return;
        end
        to = (rv_dly >= TO);
        n  = to ? TO : rv_dly + 1;
        for (int j = 0; j < n; j++) begin
            bus_rvalid = !to && (j == rv_dly);
            bus_rdata  = bus_rvalid ? rd : $urandom;
            bus_err    = bus_rvalid ? err : 1'($urandom_range(0, 1));
            @(negedge clk);
            check("wait_req", 32'(bus_req), 32'd0);
            check("wait_stall", 32'(StallM), 32'(j != n - 1));
            tick();
        end
        exp_q.push_back((to || err) ? 32'd0 : ld_f(size, sgn, addr[1:0], rd));
        exp_fault  = to || err;
        MemReqM    = 1'b0;
        bus_err    = 1'b0;
        bus_rvalid = to ? 1'b1 : 1'b0;
        bus_rdata  = $urandom;
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset_n = 1'b0;
        MemReqM = 1'b0; MemWriteM = 1'b0; MemSizeM = 2'b00; MemSignedM = 1'b0;
        ALUResultM = '0; WriteDataM = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_be", 32'(bus_be), 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_stall", 32'(StallM), 32'd0);
        check("rst_rd", ReadDataW, 32'd0);
        reset_n = 1'b1;
        tick();

        // store byte with grant after two cycles
        txn(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, '0, 2, 0, 1'b0);
        idle();
        // signed then unsigned half load from upper lane
        txn(1'b0, 2'd1, 1'b1, 32'h0000_2002, '0, 32'h8001_1234, 0, 0, 1'b0);
        txn(1'b0, 2'd1, 1'b0, 32'h0000_2002, '0, 32'h8001_1234, 0, 0, 1'b0);
        idle();
        // misaligned word
        txn(1'b0, 2'd2, 1'b0, 32'h0000_3001, '0, '0, 0, 0, 1'b0);
        idle();
        // read timeout followed by a late rvalid
        txn(1'b0, 2'd2, 1'b0, 32'h0000_4000, '0, 32'h1234_5678, 1, TO + 2, 1'b0);
        idle();
        idle();
        // write bus error, then a store back to back
        txn(1'b1, 2'd2, 1'b0, 32'h0000_5000, 32'hDEAD_BEEF, '0, 0, 0, 1'b1);
        txn(1'b1, 2'd1, 1'b0, 32'h0000_5006, 32'h0000_CAFE, '0, 1, 0, 1'b0);
        idle();

        // reset asserted while a load waits for its grant
        MemReqM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'b10; ALUResultM = 32'h0000_6000;
        @(negedge clk);
        chk_common();
        tick();
        @(negedge clk);
        check("pre_rst_req", 32'(bus_req), 32'd1);
        #2;
        reset_n = 1'b0;
        MemReqM = 1'b0;
        #1;
        check("mid_rst_req", 32'(bus_req), 32'd0);
        check("mid_rst_addr", bus_addr, 32'd0);
        check("mid_rst_be", 32'(bus_be), 32'd0);
        check("mid_rst_stall", 32'(StallM), 32'd0);
        check("mid_rst_rd", ReadDataW, 32'd0);
        @(posedge clk);
        bus_gnt = 1'b1; bus_rvalid = 1'b1;
        tick();
        reset_n = 1'b1;
        bus_gnt = 1'b0;
        exp_rd = '0; exp_fault = 1'b0; exp_mis = 1'b0;
        exp_q.delete();
        idle();
        txn(1'b0, 2'd0, 1'b1, 32'h0000_7001, '0, 32'h0000_9C00, 1, 1, 1'b0);
        idle();

        // randomized traffic
        for (int k = 0; k < 120; k++) begin
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
